alarm_slot_scheduler: RTL and testbench

//  Multi-slot alarm scheduler for the digital alarm clock. Holds NUM_SLOTS programmable
//  HH:MM alarms, compares them against the running BCD time once per second, picks which

---
 rtl/alarm_slot_if.sv | 44 ++++
 rtl/alarm_slot_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_alarm_slot_scheduler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_slot_if.sv
// Alarm scheduler bus: BCD time in, slot programming,
// snooze/stop controls, and buzzer/status outputs.
interface alarm_slot_if #(
  parameter int NUM_SLOTS = 4,
  parameter int SW        = $clog2(NUM_SLOTS)
);
  logic [1:0]           t_hour1;
  logic [3:0]           t_hour0;
  logic [3:0]           t_min1;
  logic [3:0]           t_min0;
  logic [3:0]           t_sec1;
  logic [3:0]           t_sec0;
  logic                 wr_en;
  logic [SW-1:0]        wr_slot;
  logic                 wr_enable;
  logic [1:0]           wr_hour1;
  logic [3:0]           wr_hour0;
  logic [3:0]           wr_min1;
  logic [3:0]           wr_min0;
  logic                 snooze;
  logic                 stop;
  logic                 alarm;
  logic [SW-1:0]        active_slot;
  logic                 snoozing;
  logic [NUM_SLOTS-1:0] pending;

  modport master (
    output t_hour1, t_hour0, t_min1, t_min0,
    output t_sec1, t_sec0,
    output wr_en, wr_slot, wr_enable,
    output wr_hour1, wr_hour0, wr_min1, wr_min0,
    output snooze, stop,
    input  alarm, active_slot, snoozing, pending
  );

  modport slave (
    input  t_hour1, t_hour0, t_min1, t_min0,
    input  t_sec1, t_sec0,
    input  wr_en, wr_slot, wr_enable,
    input  wr_hour1, wr_hour0, wr_min1, wr_min0,
    input  snooze, stop,
    output alarm, active_slot, snoozing, pending
  );
endinterface

// File: rtl/alarm_slot_scheduler.sv
// Multi-slot HH:MM alarm scheduler: match, arbitrate
// (lowest slot wins), ring / snooze / timeout sequencing.
module alarm_slot_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3,
  parameter int SW         = $clog2(NUM_SLOTS)
) (
  input  logic         CLK_1s,
  input  logic         reset,
  alarm_slot_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RING,
    S_SNOOZE
  } state_t;

  typedef struct packed {
    logic       armed;
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } slot_t;

  localparam logic [9:0] RING_LAST = 10'(RING_SEC - 1);
  localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SEC - 1);
  localparam logic [3:0] SNZ_MAX   = 4'(MAX_SNOOZE);

  slot_t                r_slot [NUM_SLOTS];
  state_t               r_state;
  state_t               w_state_nxt;
  logic [9:0]           r_ring_cnt;
  logic [9:0]           w_ring_cnt_nxt;
  logic [9:0]           r_snz_tmr;
  logic [9:0]           w_snz_tmr_nxt;
  logic [3:0]           r_snz_cnt;
  logic [3:0]           w_snz_cnt_nxt;
  logic [SW-1:0]        r_active;
  logic [SW-1:0]        w_active_nxt;
  logic [NUM_SLOTS-1:0] r_pending;
  logic [NUM_SLOTS-1:0] w_pending_nxt;
  logic [NUM_SLOTS-1:0] w_match;
  logic [NUM_SLOTS-1:0] w_req;
  logic [NUM_SLOTS-1:0] w_active_oh;
  logic [NUM_SLOTS-1:0] w_first_oh;
  logic [SW-1:0]        w_first;
  logic                 w_sec_zero;
  logic                 r_alarm;

  assign w_sec_zero = (bus.t_sec1 == 4'd0) &&
                      (bus.t_sec0 == 4'd0);
  assign w_req      = w_match | r_pending;

  // per-slot compare against the running time
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_match[i] = r_slot[i].armed &&
                   (r_slot[i].h1 == bus.t_hour1) &&
                   (r_slot[i].h0 == bus.t_hour0) &&
                   (r_slot[i].m1 == bus.t_min1) &&
                   (r_slot[i].m0 == bus.t_min0) &&
                   w_sec_zero;
    end
  end

  // lowest requesting slot, index and one-hot
  always_comb begin
    w_first    = '0;
    w_first_oh = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_first       = SW'(i);
        w_first_oh    = '0;
        w_first_oh[i] = 1'b1;
      end
    end
  end

  // one-hot of the slot currently being served
  always_comb begin
    w_active_oh = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_active_oh[i] = (r_active == SW'(i));
    end
  end

  // slot programming; takes effect from the next edge
  always_ff @(posedge CLK_1s or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slot[i] <= '0;
      end
    end else if (bus.wr_en) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (bus.wr_slot == SW'(i)) begin
          r_slot[i] <= {bus.wr_enable,
                        bus.wr_hour1, bus.wr_hour0,
                        bus.wr_min1, bus.wr_min0};
        end
      end
    end
  end

  // FSM next-state, counters and pending bookkeeping
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_tmr_nxt  = r_snz_tmr;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_active_nxt   = r_active;
    w_pending_nxt  = r_pending;
    unique case (r_state)
      S_IDLE: begin
        if (bus.stop) begin
          w_pending_nxt = '0;
        end else if (|w_req) begin
          w_state_nxt    = S_RING;
          w_active_nxt   = w_first;
          w_pending_nxt  = w_req & ~w_first_oh;
          w_ring_cnt_nxt = '0;
          w_snz_cnt_nxt  = '0;
        end
      end
      S_RING: begin
        if (bus.stop) begin
          w_state_nxt   = S_IDLE;
          w_pending_nxt = '0;
        end else begin
          w_pending_nxt = r_pending |
                          (w_match & ~w_active_oh);
          if (bus.snooze && (r_snz_cnt < SNZ_MAX)) begin
            w_state_nxt   = S_SNOOZE;
            w_snz_cnt_nxt = r_snz_cnt + 4'd1;
            w_snz_tmr_nxt = '0;
          end else if (r_ring_cnt == RING_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_ring_cnt_nxt = r_ring_cnt + 10'd1;
          end
        end
      end
      S_SNOOZE: begin
        if (bus.stop) begin
          w_state_nxt   = S_IDLE;
          w_pending_nxt = '0;
        end else begin
          w_pending_nxt = r_pending |
                          (w_match & ~w_active_oh);
          if (r_snz_tmr == SNZ_LAST) begin
            w_state_nxt    = S_RING;
            w_ring_cnt_nxt = '0;
          end else begin
            w_snz_tmr_nxt = r_snz_tmr + 10'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // state, counters and registered buzzer drive
  always_ff @(posedge CLK_1s or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ring_cnt <= '0;
      r_snz_tmr  <= '0;
      r_snz_cnt  <= '0;
      r_active   <= '0;
      r_pending  <= '0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_tmr  <= w_snz_tmr_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_active   <= w_active_nxt;
      r_pending  <= w_pending_nxt;
      r_alarm    <= (w_state_nxt == S_RING);
    end
  end

  assign bus.alarm       = r_alarm;
  assign bus.active_slot = r_active;
  assign bus.snoozing    = (r_state == S_SNOOZE);
  assign bus.pending     = r_pending;

endmodule

// File: tb/tb_alarm_slot_scheduler.sv
// Scoreboard bench for alarm_slot_scheduler:
// directed stimulus queues expectations, monitor checks.
module tb_alarm_slot_scheduler;

  localparam int NS = 4;

  logic CLK_1s = 1'b0;
  logic reset;

  alarm_slot_if #(.NUM_SLOTS(NS)) bus ();

  alarm_slot_scheduler #(
    .NUM_SLOTS (NS),
    .SNOOZE_SEC(300),
    .RING_SEC  (60),
    .MAX_SNOOZE(3)
  ) dut (
    .CLK_1s(CLK_1s),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK_1s = ~CLK_1s;

  typedef struct packed {
    logic       chk;
    logic       cs;
    logic       a;
    logic [1:0] s;
    logic       sz;
    logic [3:0] p;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_vec = 0;
  int    n_bad = 0;
  exp_t  m_e;
  string m_nm;

  task automatic cmp(input string nm, input exp_t e);
    logic bad;
    n_vec++;
    bad = (bus.alarm !== e.a) ||
          (bus.snoozing !== e.sz) ||
          (bus.pending !== e.p) ||
          (e.cs && (bus.active_slot !== e.s));
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got alarm=%b slot=%0d snz=%b pend=%b, want alarm=%b slot=%0d(chk=%b) snz=%b pend=%b",
               nm, bus.alarm, bus.active_slot, bus.snoozing,
               bus.pending, e.a, e.s, e.cs, e.sz, e.p);
    end
  endtask

  // monitor: one expectation per clock edge
  always @(posedge CLK_1s) begin
    #1;
    if (q.size() != 0) begin
      m_e  = q.pop_front();
      m_nm = qn.pop_front();
      if (m_e.chk) cmp(m_nm, m_e);
    end
  end

  task automatic step(input string nm, input logic chk,
                      input logic a, input logic [1:0] s,
                      input logic sz, input logic [3:0] p);
    exp_t e;
    e = {chk, a | sz, a, s, sz, p};
    q.push_back(e);
    qn.push_back(nm);
    @(posedge CLK_1s);
    @(negedge CLK_1s);
  endtask

  task automatic rstep(input string nm);
    exp_t e;
    e = {1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0};
    q.push_back(e);
    qn.push_back(nm);
    @(posedge CLK_1s);
    @(negedge CLK_1s);
  endtask

  task automatic arst_check(input string nm);
    exp_t e;
    e = {1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0};
    reset = 1'b1;
    #1;
    cmp(nm, e);
  endtask

  task automatic set_time(input logic [1:0] h1,
                          input logic [3:0] h0,
                          input logic [3:0] m1,
                          input logic [3:0] m0,
                          input logic [3:0] s1,
                          input logic [3:0] s0);
    bus.t_hour1 = h1;
    bus.t_hour0 = h0;
    bus.t_min1  = m1;
    bus.t_min0  = m0;
    bus.t_sec1  = s1;
    bus.t_sec0  = s0;
  endtask

  task automatic wr(input logic [1:0] sl, input logic en,
                    input logic [1:0] h1, input logic [3:0] h0,
                    input logic [3:0] m1, input logic [3:0] m0);
    bus.wr_en     = 1'b1;
    bus.wr_slot   = sl;
    bus.wr_enable = en;
    bus.wr_hour1  = h1;
    bus.wr_hour0  = h0;
    bus.wr_min1   = m1;
    bus.wr_min0   = m0;
  endtask

  initial begin
    reset = 1'b1;
    set_time(0, 0, 0, 0, 0, 0);
    wr(0, 0, 0, 0, 0, 0);
    bus.wr_en  = 1'b0;
    bus.snooze = 1'b0;
    bus.stop   = 1'b0;
    @(negedge CLK_1s);
    rstep("reset");
    reset = 1'b0;

    // slot0 07:30 basic hit and untouched auto-stop
    set_time(0, 7, 2, 9, 5, 9);
    wr(0, 1, 0, 7, 3, 0);
    step("wr0", 0, 0, 0, 0, 4'd0);
    bus.wr_en = 1'b0;
    step("pre", 1, 0, 0, 0, 4'd0);
    set_time(0, 7, 3, 0, 0, 0);
    step("hit", 1, 1, 0, 0, 4'd0);
    set_time(0, 7, 3, 0, 0, 1);
    for (int k = 1; k <= 60; k++) begin
      step($sformatf("ring%0d", k), 1, k < 60, 0, 0, 4'd0);
    end

    // snooze three times, fourth request ignored
    set_time(0, 7, 3, 0, 0, 0);
    step("rehit", 1, 1, 0, 0, 4'd0);
    set_time(0, 7, 3, 0, 0, 1);
    for (int n = 1; n <= 3; n++) begin
      bus.snooze = 1'b1;
      step($sformatf("snz%0d", n), 1, 0, 0, 1, 4'd0);
      bus.snooze = 1'b0;
      for (int k = 1; k <= 300; k++) begin
        if (n == 1 && k == 5) bus.snooze = 1'b1;
        step($sformatf("sleep%0d_%0d", n, k), 1,
             k == 300, 0, k != 300, 4'd0);
        bus.snooze = 1'b0;
      end
    end
    bus.snooze = 1'b1;
    step("snz4", 1, 1, 0, 0, 4'd0);
    bus.snooze = 1'b0;
    step("ring_on", 1, 1, 0, 0, 4'd0);
    bus.stop = 1'b1;
    step("stop0", 1, 0, 0, 0, 4'd0);
    bus.stop = 1'b0;

    // slots 1 and 2 both at 08:00
    wr(1, 1, 0, 8, 0, 0);
    step("wr1", 0, 0, 0, 0, 4'd0);
    wr(2, 1, 0, 8, 0, 0);
    step("wr2", 0, 0, 0, 0, 4'd0);
    bus.wr_en = 1'b0;
    set_time(0, 8, 0, 0, 0, 0);
    step("dual", 1, 1, 1, 0, 4'b0100);
    set_time(0, 8, 0, 0, 0, 1);
    step("dual2", 1, 1, 1, 0, 4'b0100);
    bus.stop = 1'b1;
    step("dstop", 1, 0, 0, 0, 4'd0);
    bus.stop = 1'b0;
    step("didle", 1, 0, 0, 0, 4'd0);

    // stop in IDLE suppresses a same-edge match
    set_time(0, 8, 0, 0, 0, 0);
    bus.stop = 1'b1;
    step("istop", 1, 0, 0, 0, 4'd0);
    bus.stop = 1'b0;
    set_time(0, 8, 0, 0, 0, 1);
    step("istop2", 1, 0, 0, 0, 4'd0);

    // slot2 06:00 ringing, slot0 06:01 goes pending
    wr(2, 1, 0, 6, 0, 0);
    step("wr2b", 0, 0, 0, 0, 4'd0);
    wr(0, 1, 0, 6, 0, 1);
    step("wr0b", 0, 0, 0, 0, 4'd0);
    bus.wr_en = 1'b0;
    set_time(0, 6, 0, 0, 0, 0);
    step("s2hit", 1, 1, 2, 0, 4'd0);
    set_time(0, 6, 0, 0, 0, 1);
    for (int k = 1; k <= 61; k++) begin
      if (k == 10) set_time(0, 6, 0, 0, 0, 0);
      if (k == 30) set_time(0, 6, 0, 1, 0, 0);
      if (k == 20) wr(2, 0, 0, 6, 0, 0);
      if (k < 30)
        step($sformatf("pq%0d", k), 1, 1, 2, 0, 4'd0);
      else if (k < 60)
        step($sformatf("pq%0d", k), 1, 1, 2, 0, 4'b0001);
      else if (k == 60)
        step("pq_idle", 1, 0, 0, 0, 4'b0001);
      else
        step("pq_serve", 1, 1, 0, 0, 4'd0);
      bus.wr_en = 1'b0;
      if (k >= 30) set_time(0, 6, 0, 1, 0, 1);
      else         set_time(0, 6, 0, 0, 0, 1);
    end

    // reset while ringing
    step("r0", 1, 1, 0, 0, 4'd0);
    arst_check("arst_ring");
    rstep("rst_ring");
    reset = 1'b0;
    set_time(0, 6, 0, 1, 0, 0);
    step("disarmed", 1, 0, 0, 0, 4'd0);

    // reset while snoozing
    wr(3, 1, 0, 9, 1, 5);
    step("wr3", 0, 0, 0, 0, 4'd0);
    bus.wr_en = 1'b0;
    set_time(0, 9, 1, 5, 0, 0);
    step("s3hit", 1, 1, 3, 0, 4'd0);
    set_time(0, 9, 1, 5, 0, 1);
    bus.snooze = 1'b1;
    step("s3snz", 1, 0, 3, 1, 4'd0);
    bus.snooze = 1'b0;
    step("s3slp", 1, 0, 3, 1, 4'd0);
    arst_check("arst_snz");
    rstep("rst_snz");
    reset = 1'b0;
    set_time(0, 9, 1, 5, 0, 0);
    step("post", 1, 0, 0, 0, 4'd0);

    @(posedge CLK_1s);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d queued, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
